// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, scan-code constants and the set-2 to HID lookup for the PS/2 keycode receiver.
// Ports: none (package). Imported by ps2_frame_rx and ps2_keycode_rx.
// Optional feature macro used by the importing top: PS2_TWO_KEY_EN.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] HID_UP    = 8'h52;
    localparam logic [7:0] HID_DOWN  = 8'h51;
    localparam logic [7:0] HID_LEFT  = 8'h50;
    localparam logic [7:0] HID_RIGHT = 8'h4F;
    localparam logic [7:0] HID_W     = 8'h1A;
    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_S     = 8'h16;
    localparam logic [7:0] HID_D     = 8'h07;
    localparam logic [7:0] HID_ENTER = 8'h28;
    localparam logic [7:0] HID_SPACE = 8'h2C;
    localparam logic [7:0] HID_ESC   = 8'h29;

    // Returns {hit, hid}. Extended and plain tables are disjoint on purpose:
    // an arrow code without its E0 prefix is not a recognised key.
    function automatic logic [8:0] set2_to_hid(input logic ext, input logic [7:0] code);
        logic [8:0] r;
        r = 9'h000;
        if (ext) begin
            case (code)
                8'h75:   r = {1'b1, HID_UP};
                8'h72:   r = {1'b1, HID_DOWN};
                8'h6B:   r = {1'b1, HID_LEFT};
                8'h74:   r = {1'b1, HID_RIGHT};
                default: r = 9'h000;
            endcase
        end else begin
            case (code)
                8'h1D:   r = {1'b1, HID_W};
                8'h1C:   r = {1'b1, HID_A};
                8'h1B:   r = {1'b1, HID_S};
                8'h23:   r = {1'b1, HID_D};
                8'h5A:   r = {1'b1, HID_ENTER};
                8'h29:   r = {1'b1, HID_SPACE};
                8'h76:   r = {1'b1, HID_ESC};
                default: r = 9'h000;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises PS2_CLK/PS2_DAT, frames 11-bit PS/2 words, checks start/parity/stop and inactivity timeout.
// Ports: i_clk, i_rst (async, active-high), i_ps2_clk, i_ps2_dat in; o_byte_valid (1-cycle pulse), o_byte, o_frame_err (1-cycle pulse) out.
// Latency: o_byte_valid/o_byte one cycle after the stop-bit falling edge is detected; no backpressure (keyboard cannot be stalled).
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic [3:0]             r_bit_cnt;
    logic [TW-1:0]          r_to_cnt;
    logic [7:0]             r_data;
    logic                   r_par;
    logic [7:0]             r_byte;
    logic                   r_valid;
    logic                   r_err;

    logic w_clk_s;
    logic w_dat_s;
    logic w_fall;

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
    assign w_fall  = r_clk_prev & ~w_clk_s;

    // Sync flops reset to 1 (idle bus level) so release of reset never looks like an edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
            r_clk_prev <= w_clk_s;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bit_cnt <= 4'd0;
            r_to_cnt  <= '0;
            r_data    <= 8'h00;
            r_par     <= 1'b0;
            r_byte    <= 8'h00;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_fall) begin
                // An edge always beats a coincident timeout.
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd0) begin
                    if (w_dat_s) r_err <= 1'b1;
                    else         r_bit_cnt <= 4'd1;
                end else if (r_bit_cnt <= 4'd8) begin
                    r_data    <= {w_dat_s, r_data[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else if (r_bit_cnt == 4'd9) begin
                    r_par     <= w_dat_s;
                    r_bit_cnt <= 4'd10;
                end else begin
                    // Start was already proven 0 when leaving count 0.
                    r_bit_cnt <= 4'd0;
                    if (w_dat_s && (^{r_data, r_par})) begin
                        r_valid <= 1'b1;
                        r_byte  <= r_data;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_to_cnt == TO_LIMIT) begin
                    r_err     <= 1'b1;
                    r_bit_cnt <= 4'd0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign o_byte_valid = r_valid;
    assign o_byte       = r_byte;
    assign o_frame_err  = r_err;

endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 set-2 keyboard receiver producing the 16-bit HID keycode word used by the game logic.
// Ports: Clk, Reset (async, active-high), PS2_CLK, PS2_DAT in; keycode[15:0], key_valid, frame_err, scan_byte[7:0] out.
// Latency: keycode/key_valid 2 Clk after stop-bit edge detect; no backpressure. Macro PS2_TWO_KEY_EN enables a second held-key slot.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [15:0] keycode,
    output logic        key_valid,
    output logic        frame_err,
    output logic [7:0]  scan_byte
);
    logic       w_byte_valid;
    logic [7:0] w_byte;
    logic       w_frame_err;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_frame (
        .i_clk        (Clk),
        .i_rst        (Reset),
        .i_ps2_clk    (PS2_CLK),
        .i_ps2_dat    (PS2_DAT),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_frame_err  (w_frame_err)
    );

    dec_state_t  r_state;
    logic [15:0] r_keycode;
    logic        r_key_valid;

    dec_state_t  w_state_nxt;
    logic [15:0] w_keycode_nxt;
    logic        w_key_valid_nxt;
    logic [8:0]  w_map;
    logic        w_ext;
    logic        w_make;
    logic        w_break;

    assign w_ext = (r_state == EXT) || (r_state == EXT_BRK);
    assign w_map = set2_to_hid(w_ext, w_byte);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_keycode   <= 16'h0000;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_keycode   <= w_keycode_nxt;
            r_key_valid <= w_key_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_break     = 1'b0;
        if (w_byte_valid) begin
            case (r_state)
                IDLE: begin
                    if (w_byte == PS2_EXT)      w_state_nxt = EXT;
                    else if (w_byte == PS2_BRK) w_state_nxt = BRK;
                    else                        w_make = w_map[8];
                end
                EXT: begin
                    if (w_byte == PS2_BRK) begin
                        w_state_nxt = EXT_BRK;
                    end else begin
                        w_state_nxt = IDLE;
                        w_make      = w_map[8];
                    end
                end
                BRK, EXT_BRK: begin
                    w_state_nxt = IDLE;
                    w_break     = w_map[8];
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // HID codes are never 0, so comparing against an empty slot cannot match.
    always_comb begin
        w_keycode_nxt   = r_keycode;
        w_key_valid_nxt = w_make | w_break;
`ifdef PS2_TWO_KEY_EN
        if (w_make) begin
            if (w_map[7:0] != r_keycode[7:0] && w_map[7:0] != r_keycode[15:8]) begin
                if (r_keycode[7:0] != 8'h00) w_keycode_nxt = {r_keycode[7:0], w_map[7:0]};
                else                         w_keycode_nxt = {8'h00, w_map[7:0]};
            end
        end else if (w_break) begin
            if (w_map[7:0] == r_keycode[7:0])       w_keycode_nxt = {8'h00, r_keycode[15:8]};
            else if (w_map[7:0] == r_keycode[15:8]) w_keycode_nxt = {8'h00, r_keycode[7:0]};
        end
`else
        if (w_make) begin
            w_keycode_nxt = {8'h00, w_map[7:0]};
        end else if (w_break) begin
            if (w_map[7:0] == r_keycode[7:0]) w_keycode_nxt = 16'h0000;
        end
`endif
    end

    assign keycode   = r_keycode;
    assign key_valid = r_key_valid;
    assign frame_err = w_frame_err;
    assign scan_byte = w_byte;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb_ps2_keycode_rx: directed bench for ps2_keycode_rx driving bit-level PS/2 frames.
// Ports: none (top-level bench); drives Clk/Reset/PS2_CLK/PS2_DAT, observes all DUT outputs.
// Expected values are hand-derived from the keyboard protocol and key map; PS2_TWO_KEY_EN selects the two-slot expectations.
module tb_ps2_keycode_rx;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DAT = 1'b1;
    logic [15:0] keycode;
    logic        key_valid;
    logic        frame_err;
    logic [7:0]  scan_byte;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int kv_cnt   = 0;
    int fe_cnt   = 0;
    int kv_lat   = -1;

    localparam int HALF = 8;

    ps2_keycode_rx dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .keycode   (keycode),
        .key_valid (key_valid),
        .frame_err (frame_err),
        .scan_byte (scan_byte)
    );

    always #10 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always begin
        @(posedge Clk);
        #1;
        if (key_valid) begin
            kv_cnt = kv_cnt + 1;
            kv_lat = cyc - fall_cyc;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge Clk);
        #5;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = f[i];
            wait_cyc(HALF);
            PS2_CLK  = 1'b0;
            fall_cyc = cyc;
            wait_cyc(HALF);
            PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits({1'b1, ~^b, b, 1'b0}, 11);
        wait_cyc(12);
    endtask

    logic [7:0] bad_b;

    initial begin
        wait_cyc(3);
        chk("rst_keycode",   keycode, 16'h0000);
        chk("rst_key_valid", {15'h0, key_valid}, 16'h0000);
        chk("rst_frame_err", {15'h0, frame_err}, 16'h0000);
        chk("rst_scan_byte", {8'h0, scan_byte}, 16'h0000);
        Reset = 1'b0;
        wait_cyc(5);

        // Extended up-arrow make, then its break.
        send_byte(8'hE0);
        send_byte(8'h75);
        chk("up_make",     keycode, 16'h0052);
        chk("up_kv_count", kv_cnt[15:0], 16'd1);
        chk("latency",     kv_lat[15:0], 16'd4);
        chk("scan_75",     {8'h0, scan_byte}, 16'h0075);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        chk("up_break",    keycode, 16'h0000);
        chk("up_kv_brk",   kv_cnt[15:0], 16'd2);

        // W then A overlap, typematic repeat, out-of-order breaks.
        send_byte(8'h1D);
        chk("w_make", keycode, 16'h001A);
        send_byte(8'h1C);
`ifdef PS2_TWO_KEY_EN
        chk("a_make", keycode, 16'h1A04);
`else
        chk("a_make", keycode, 16'h0004);
`endif
        send_byte(8'h1C);
        chk("a_repeat_kv", kv_cnt[15:0], 16'd5);
        send_byte(8'hF0);
        send_byte(8'h1D);
        chk("w_break_not_held", keycode, 16'h0004);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("a_break", keycode, 16'h0000);
        chk("wa_kv",   kv_cnt[15:0], 16'd7);

        // Controller replies are unmapped.
        send_byte(8'hAA);
        send_byte(8'hFA);
        chk("replies_keycode", keycode, 16'h0000);
        chk("replies_kv",      kv_cnt[15:0], 16'd7);

        // 6B with even parity: rejected, last good byte kept.
        bad_b = 8'h6B;
        send_bits({1'b1, ^bad_b, bad_b, 1'b0}, 11);
        wait_cyc(12);
        chk("parity_err",  fe_cnt[15:0], 16'd1);
        chk("parity_scan", {8'h0, scan_byte}, 16'h00FA);
        send_byte(8'h5A);
        chk("enter_make", keycode, 16'h0028);
        send_byte(8'hF0);
        send_byte(8'h5A);
        chk("enter_break", keycode, 16'h0000);

        // Bad stop bit.
        bad_b = 8'h1C;
        send_bits({1'b0, ~^bad_b, bad_b, 1'b0}, 11);
        wait_cyc(12);
        chk("stop_err",     fe_cnt[15:0], 16'd2);
        chk("stop_keycode", keycode, 16'h0000);

        // Start bit of 1.
        send_bits(11'h001, 1);
        wait_cyc(12);
        chk("start_err", fe_cnt[15:0], 16'd3);

        // Partial frame then silence.
        bad_b = 8'h29;
        send_bits({1'b1, ~^bad_b, bad_b, 1'b0}, 5);
        wait_cyc(49900);
        chk("timeout_early", fe_cnt[15:0], 16'd3);
        wait_cyc(200);
        chk("timeout_err", fe_cnt[15:0], 16'd4);
        send_byte(8'h29);
        chk("space_make", keycode, 16'h002C);
        chk("space_kv",   kv_cnt[15:0], 16'd10);

        // Reset after a lone E0 prefix.
        send_byte(8'hE0);
        Reset = 1'b1;
        wait_cyc(1);
        chk("mid_rst_keycode", keycode, 16'h0000);
        chk("mid_rst_scan",    {8'h0, scan_byte}, 16'h0000);
        chk("mid_rst_kv",      {15'h0, key_valid}, 16'h0000);
        chk("mid_rst_fe",      {15'h0, frame_err}, 16'h0000);
        wait_cyc(2);
        Reset = 1'b0;
        wait_cyc(5);
        send_byte(8'h75);
        chk("post_rst_keycode", keycode, 16'h0000);
        chk("post_rst_kv",      kv_cnt[15:0], 16'd10);
        chk("post_rst_scan",    {8'h0, scan_byte}, 16'h0075);

        // Two arrows held, release the newer.
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'h74);
`ifdef PS2_TWO_KEY_EN
        chk("two_make", keycode, 16'h524F);
`else
        chk("two_make", keycode, 16'h004F);
`endif
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h74);
`ifdef PS2_TWO_KEY_EN
        chk("two_break", keycode, 16'h0052);
`else
        chk("two_break", keycode, 16'h0000);
`endif
        chk("two_kv", kv_cnt[15:0], 16'd13);
        chk("total_fe", fe_cnt[15:0], 16'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_keycode_rx.md
Name: ps2_keycode_rx

Overview:
Receives PS/2 scan-code set 2 traffic from a keyboard and translates it into the same 16-bit USB-HID keycode word the game logic already consumes from the Nios keycode PIO. It replaces the USB/HPI path as a keyboard source for the frog controls. Output semantics are fixed: the keycode holds the HID usage while a key is held and returns to 0 on release.

Parameters:
TIMEOUT_CYCLES, 50000, Clk cycles without a PS/2 falling edge before a partial frame is discarded (1 ms at 50 MHz).
SYNC_STAGES, 2, flip-flop stages on PS2_CLK/PS2_DAT; legal values are 2 or 3.

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  asynchronous, active-high reset
PS2_CLK  in  1  keyboard clock, asynchronous to Clk
PS2_DAT  in  1  keyboard data, asynchronous to Clk
keycode  out  16  HID usage of held key(s); 0 when no key is held
key_valid  out  1  one-cycle pulse on every accepted mapped make or break
frame_err  out  1  one-cycle pulse on a bad start, parity or stop bit, or on timeout
scan_byte  out  8  last good raw byte; debug only

Behaviour:
- Clock and reset: single clock Clk; Reset is asynchronous and active-high.
- Reset values: keycode=0, key_valid=0, frame_err=0, scan_byte=0, decoder state IDLE, bit counter 0, timeout counter 0.
- Input sync: both PS/2 lines pass through SYNC_STAGES flops. A falling edge is prev_synced=1 and synced=0. Data is sampled on the cycle the edge is detected.
- Frame: 11 bits = start(0), D0..D7 LSB first, odd parity, stop(1). The bit counter runs 0..10.
- Frame check:
  - Start bit must be 0. If it is 1, pulse frame_err and reset the counter.
  - On bit 10: if start=0, parity is odd over D+P, and stop=1, byte_valid pulses the next cycle and scan_byte updates.
  - Otherwise frame_err pulses and the byte is discarded.
- Timeout: the timeout counter clears on every falling edge. If counter>0 mid-frame and the timeout reaches TIMEOUT_CYCLES-1, pulse frame_err, set counter=0, and emit no byte.
- Decoder FSM, advancing one step per byte_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; mapped byte -> MAKE(code); anything else ignored, stay in IDLE.
  - EXT: F0 -> EXT_BRK; mapped extended byte -> MAKE, then IDLE; other -> IDLE.
  - BRK: mapped byte -> BREAK, then IDLE; other -> IDLE.
  - EXT_BRK: mapped extended byte -> BREAK, then IDLE; other -> IDLE.
- Map (set2 -> HID):
  - Extended: 75->52 (up), 72->51 (down), 6B->50 (left), 74->4F (right).
  - Plain: 1D->1A (W), 1C->04 (A), 1B->16 (S), 23->07 (D), 5A->28 (Enter), 29->2C (Space), 76->29 (Esc).
  - Unmapped bytes are ignored, including controller replies AA, FA, FE and the E1 Pause sequence.
- MAKE: keycode[7:0]=hid, [15:8]=0. A newer make overrides a held key. key_valid pulses.
- BREAK: if hid==keycode[7:0], keycode=0. A break for a non-held key leaves keycode unchanged. key_valid pulses in both cases.
- Typematic repeat (a repeated make of the same key) leaves keycode unchanged and pulses key_valid again.
- Latency: keycode and key_valid update 2 Clk cycles after the falling edge of the stop bit is detected, i.e. byte_valid plus one.
- Reset mid-frame or mid-prefix returns everything to its reset values immediately. No stale prefix survives reset.
- Simultaneous timeout and falling edge in the same cycle: the edge wins and the timeout counter clears.

Optional Feature:
Macro PS2_TWO_KEY_EN.
- Defined: track two held keys, matching the USB report's second key slot.
  - A make of a new key while slot[7:0] is occupied moves the old code to [15:8] and puts the new code in [7:0].
  - A make of a key already in either slot causes no change.
  - A break clears the matching slot. If [7:0] is cleared, [15:8] shifts down and [15:8] becomes 0.
- Undefined: single-key behaviour as above; keycode[15:8] is constant 0.

Decomposition:
- Package ps2_pkg:
  - decoder state enum {IDLE, EXT, BRK, EXT_BRK}
  - scan constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0
  - HID usage constants for arrows, WASD, Enter, Space and Esc
  - function set2_to_hid(ext, byte) returning {hit, hid[7:0]}
- One sub-module, ps2_frame_rx: synchronizer, edge detect, bit counter, parity/timeout checks. Outputs: byte_valid, byte, frame_err.
- ps2_keycode_rx holds the decoder FSM and keycode register.

Test Plan:
- Send E0 75 -> keycode=0x0052, key_valid pulses once. Then send E0 F0 75 -> keycode=0x0000.
- Send 1D, then 1C -> keycode 0x001A then 0x0004. Send F0 1D -> keycode stays 0x0004. Send F0 1C -> keycode=0x0000.
- Send 6B with a parity bit giving even parity -> frame_err pulses, keycode unchanged, decoder stays IDLE.
- Send 5 bits of a frame, then idle for 50000 cycles -> frame_err pulses once. Then send 29 -> keycode=0x002C.
- Send E0, assert Reset for 3 cycles, then send 75 -> keycode=0x0000 (75 alone is unmapped) and all outputs show reset values during Reset.
- With PS2_TWO_KEY_EN, send E0 75 then E0 74 -> keycode=0x524F. Then send E0 F0 74 -> keycode=0x0052.
